adc_sample_uart_tx: RTL

//  Stage directly downstream of the ADC board interface. Takes 16-bit ADC samples and

---
 rtl/adc_link_pkg.sv | 30 +++
 rtl/uart_tx_byte.sv | 124 ++++++++++++
 rtl/adc_sample_uart_tx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/adc_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : adc_link_pkg                                                     |
// | Purpose : Shared definitions for the ADC sample -> host UART link: default |
// |           sync byte, frame length, serialiser state encoding and the frame |
// |           checksum function.                                               |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package adc_link_pkg;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int         FRAME_BYTES   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Checksum byte closing every frame: XOR of the sync byte and both sample bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] hi,
                                           input logic [7:0] lo,
                                           input logic [7:0] sync = DEF_SYNC_BYTE);
    return sync ^ hi ^ lo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : uart_tx_byte                                                     |
// | Purpose : 8N1 byte serialiser. One start bit, 8 data bits LSB first, one   |
// |           stop bit, each exactly DIV clk cycles. A byte offered during the |
// |           last stop-bit cycle is chained with no idle gap.                 |
// | Ports   : clk, rst_n (async, active-low)                                   |
// |           byte_in[7:0], byte_valid -> byte to send                         |
// |           byte_ready  <- a byte offered this cycle is taken                |
// |           byte_done   <- pulse in the last cycle of the stop bit           |
// |           txd         <- serial line, registered, idles high               |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module uart_tx_byte
  import adc_link_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       byte_done,
  output logic       txd
);

  localparam int               CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0] C_RELOAD = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

  tx_state_t        r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shreg;
  logic             r_txd;
  logic             r_byte_done;

  logic w_bit_end;

  assign w_bit_end  = (r_baud_cnt == '0);
  // Ready while idle, and also in the final stop-bit cycle so consecutive
  // bytes run back to back.
  assign byte_ready = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
  assign byte_done  = r_byte_done;
  assign txd        = r_txd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_txd       <= 1'b1;
      r_byte_done <= 1'b0;
    end else begin
      // Raised one cycle early so the pulse lands on the final stop-bit cycle;
      // DIV >= 2 guarantees the counter passes through 1.
      r_byte_done <= (r_state == STOP) && (r_baud_cnt == C_ONE);

      case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (byte_valid) begin
            r_shreg    <= byte_in;
            r_baud_cnt <= C_RELOAD;
            r_txd      <= 1'b0;
            r_state    <= START;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_baud_cnt <= C_RELOAD;
            r_bit_idx  <= '0;
            r_txd      <= r_shreg[0];
            r_state    <= DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= C_RELOAD;
            if (r_bit_idx == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shreg   <= {1'b0, r_shreg[7:1]};
              r_txd     <= r_shreg[1];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end
        end

        STOP: begin
          if (w_bit_end) begin
            if (byte_valid) begin
              r_shreg    <= byte_in;
              r_baud_cnt <= C_RELOAD;
              r_txd      <= 1'b0;
              r_state    <= START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end
        end

        default: begin
          r_txd   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_sample_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : adc_sample_uart_tx                                               |
// | Purpose : Serialises each accepted 16-bit ADC sample as a 4-byte 8N1 frame |
// |           SYNC, MSB, LSB, CHK on the host-link txd pin. Counts samples     |
// |           that arrive while a frame is in flight.                          |
// | Ports   : clk, rst_n (async, active-low)                                   |
// |           sample_in[15:0], sample_valid -> sample strobe                   |
// |           sample_ready <- idle, strobe accepted                            |
// |           txd          <- UART line, idles high                            |
// |           busy         <- frame in progress (~sample_ready)                |
// |           frame_done   <- pulse in last cycle of the final stop bit        |
// |           drop_cnt     <- saturating count of strobes seen while busy      |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module adc_sample_uart_tx
  import adc_link_pkg::*;
#(
  parameter int         CLK_HZ    = 50_000_000,
  parameter int         BAUD      = 115_200,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        txd,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] drop_cnt
);

  localparam int               DIV        = CLK_HZ / BAUD;
  localparam int               IDX_W      = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

  logic             r_busy;
  logic [7:0]       r_hi;
  logic [7:0]       r_lo;
  logic [7:0]       r_chk;
  logic [IDX_W-1:0] r_byte_idx;   // next frame byte to hand to the serialiser
  logic             r_pending;    // bytes remain to be handed over
  logic [15:0]      r_drop_cnt;

  logic       w_accept;
  logic       w_drop;
  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_byte_ready;
  logic       w_byte_done;
  logic       w_frame_done;

  assign w_accept = sample_valid && !r_busy;
  assign w_drop   = sample_valid && r_busy;

  // The sync byte is handed over in the accept cycle itself, which is what
  // gives the one-cycle latency to the first start bit.
  always_comb begin
    w_byte = SYNC_BYTE;
    if (r_busy) begin
      case (r_byte_idx)
        2'd1:    w_byte = r_hi;
        2'd2:    w_byte = r_lo;
        2'd3:    w_byte = r_chk;
        default: w_byte = SYNC_BYTE;
      endcase
    end
  end

  assign w_byte_valid = w_accept || r_pending;
  // The last byte's stop bit ends with nothing left to hand over.
  assign w_frame_done = w_byte_done && !r_pending;

  uart_tx_byte #(
    .DIV (DIV)
  ) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_in    (w_byte),
    .byte_valid (w_byte_valid),
    .byte_ready (w_byte_ready),
    .byte_done  (w_byte_done),
    .txd        (txd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_chk      <= '0;
      r_byte_idx <= '0;
      r_pending  <= 1'b0;
    end else if (w_accept) begin
      r_busy     <= 1'b1;
      r_hi       <= sample_in[15:8];
      r_lo       <= sample_in[7:0];
      r_chk      <= frame_chk(sample_in[15:8], sample_in[7:0], SYNC_BYTE);
      r_byte_idx <= C_IDX_ONE;
      r_pending  <= 1'b1;
    end else if (r_busy) begin
      if (r_pending && w_byte_ready) begin
        if (r_byte_idx == C_LAST_IDX) begin
          r_pending <= 1'b0;
        end else begin
          r_byte_idx <= r_byte_idx + 1'b1;
        end
      end
      if (w_frame_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Only written on a countable drop, so the count simply holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign sample_ready = !r_busy;
  assign busy         = r_busy;
  assign frame_done   = w_frame_done;
  assign drop_cnt     = r_drop_cnt;

endmodule
`default_nettype wire
